// File: rtl/gray_step_arbiter.sv
// Round-robin sequencer that lends a shared 3-bit gray step counter to two requesters
// for bursts of 1..8 increments, reporting completion and whether the counter wrapped.
module gray_step_arbiter (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Req0,
  input  logic       Req1,
  input  logic [2:0] Len0,
  input  logic [2:0] Len1,
  input  logic       CntOverflow,
  output logic       Gnt0,
  output logic       Gnt1,
  output logic       CntEn,
  output logic       CntReset,
  output logic       Done0,
  output logic       Done1,
  output logic       Wrap,
  output logic       Busy
);

  localparam int unsigned LEN_W = 3;
  localparam int unsigned REM_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE, CLEAR} state_t;

  state_t           state, state_n;
  logic [REM_W-1:0] rem, rem_n;
  logic             owner, owner_n;
  logic             last, last_n;
  logic             ovf0, ovf0_n;
  logic             gnt0_n, gnt1_n, en_n, clr_n, done0_n, done1_n, wrap_n, busy_n;
  logic             pick;
  logic [LEN_W-1:0] len_pick;

  // Both requesting: serve whoever did not go last; otherwise the lone requester.
  always_comb begin
    pick     = (Req0 & Req1) ? ~last : Req1;
    len_pick = pick ? Len1 : Len0;
  end

  always_comb begin
    state_n = state;
    rem_n   = rem;
    owner_n = owner;
    last_n  = last;
    ovf0_n  = ovf0;
    gnt0_n  = Gnt0;
    gnt1_n  = Gnt1;
    en_n    = CntEn;
    clr_n   = 1'b0;
    done0_n = 1'b0;
    done1_n = 1'b0;
    wrap_n  = 1'b0;
    busy_n  = Busy;
    case (state)
      IDLE: begin
        if (Req0 | Req1) begin
          state_n = RUN;
          gnt0_n  = ~pick;
          gnt1_n  = pick;
          en_n    = 1'b1;
          busy_n  = 1'b1;
          owner_n = pick;
          last_n  = pick;
          rem_n   = (len_pick == '0) ? REM_W'(8) : REM_W'(len_pick);
          ovf0_n  = CntOverflow;
        end
      end
      RUN: begin
        // Live overflow at the final step edge so a wrap on the last increment is seen.
        if (rem == REM_W'(1)) begin
          state_n = DONE;
          en_n    = 1'b0;
          done0_n = ~owner;
          done1_n = owner;
          wrap_n  = CntOverflow & ~ovf0;
        end else begin
          rem_n = REM_W'(rem - REM_W'(1));
        end
      end
      DONE: begin
        gnt0_n = 1'b0;
        gnt1_n = 1'b0;
        if (CntOverflow) begin
          state_n = CLEAR;
          clr_n   = 1'b1;
        end else begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      CLEAR: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        gnt0_n  = 1'b0;
        gnt1_n  = 1'b0;
        en_n    = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      rem      <= '0;
      owner    <= 1'b0;
      last     <= 1'b1;
      ovf0     <= 1'b0;
      Gnt0     <= 1'b0;
      Gnt1     <= 1'b0;
      CntEn    <= 1'b0;
      CntReset <= 1'b0;
      Done0    <= 1'b0;
      Done1    <= 1'b0;
      Wrap     <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      state    <= state_n;
      rem      <= rem_n;
      owner    <= owner_n;
      last     <= last_n;
      ovf0     <= ovf0_n;
      Gnt0     <= gnt0_n;
      Gnt1     <= gnt1_n;
      CntEn    <= en_n;
      CntReset <= clr_n;
      Done0    <= done0_n;
      Done1    <= done1_n;
      Wrap     <= wrap_n;
      Busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_gray_step_arbiter.sv
// Scoreboard bench for gray_step_arbiter: a behavioural gray counter, a burst-level
// reference model feeding an expectation queue, and a monitor that checks each completion.
module tb_gray_step_arbiter;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Req0 = 1'b0, Req1 = 1'b0;
  logic [2:0] Len0 = 3'd0, Len1 = 3'd0;
  logic       CntOverflow;
  logic       Gnt0, Gnt1, CntEn, CntReset, Done0, Done1, Wrap, Busy;

  gray_step_arbiter dut (
    .Clk(Clk), .Reset(Reset), .Req0(Req0), .Req1(Req1), .Len0(Len0), .Len1(Len1),
    .CntOverflow(CntOverflow), .Gnt0(Gnt0), .Gnt1(Gnt1), .CntEn(CntEn),
    .CntReset(CntReset), .Done0(Done0), .Done1(Done1), .Wrap(Wrap), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Counter being sequenced; overflow includes the wrap happening on this edge.
  logic [2:0] cnt_bin;
  logic       cnt_sticky;
  logic       force_ovf = 1'b0;
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_bin    <= 3'd0;
      cnt_sticky <= 1'b0;
    end else if (CntReset) begin
      cnt_bin    <= 3'd0;
      cnt_sticky <= 1'b0;
    end else begin
      if (CntEn) begin
        cnt_bin <= cnt_bin + 3'd1;
        if (cnt_bin == 3'd7) cnt_sticky <= 1'b1;
      end
      if (force_ovf) cnt_sticky <= 1'b1;
    end
  end
  assign CntOverflow = cnt_sticky | (CntEn & (cnt_bin == 3'd7));

  typedef struct {
    bit who;
    int len;
    bit wrap;
    bit clear;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  bit   abort = 1'b0;

  // Burst-level reference: counter position, sticky overflow, last winner.
  int m_pos = 0;
  bit m_sticky = 1'b0;
  bit m_last = 1'b1;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pick(bit r0, bit r1);
    if (r0 && r1) return !m_last;
    return r1;
  endfunction

  function automatic void predict(bit who, logic [2:0] len);
    exp_t e;
    int   n;
    n       = (len == 3'd0) ? 8 : int'(len);
    e.who   = who;
    e.len   = n;
    e.wrap  = !m_sticky && (m_pos + n >= 8);
    e.clear = m_sticky || (m_pos + n >= 8);
    if (e.clear) begin
      m_pos    = 0;
      m_sticky = 1'b0;
    end else begin
      m_pos = m_pos + n;
    end
    m_last = who;
    sbq.push_back(e);
  endfunction

  // Monitor: per-cycle invariants, completion checks, and the cycles that follow DONE.
  int en_cnt = 0;
  int stage = 0;
  bit cur_clear = 1'b0;
  always @(negedge Clk) begin
    if (Reset) begin
      en_cnt = 0;
      stage  = 0;
    end else begin
      exp_t e;
      chk("gnt_exclusive", int'(Gnt0 & Gnt1), 0);
      chk("en_clr_exclusive", int'(CntEn & CntReset), 0);
      if (CntEn) en_cnt++;
      if (stage == 1) begin
        chk("clr_after_done", int'(CntReset), int'(cur_clear));
        chk("busy_after_done", int'(Busy), int'(cur_clear));
        chk("done_one_cycle", int'(Done0 | Done1), 0);
        chk("gnt_released", int'(Gnt0 | Gnt1), 0);
        stage = cur_clear ? 2 : 0;
      end else if (stage == 2) begin
        chk("clr_one_cycle", int'(CntReset), 0);
        chk("busy_after_clear", int'(Busy), 0);
        stage = 0;
      end
      if (Done0 | Done1) begin
        chk("done_exclusive", int'(Done0 & Done1), 0);
        if (sbq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done: got done0=%0d done1=%0d expected none", Done0, Done1);
        end else begin
          e = sbq.pop_front();
          chk("done_owner", int'(Done1), int'(e.who));
          chk("en_cycles", en_cnt, e.len);
          chk("wrap", int'(Wrap), int'(e.wrap));
          chk("gnt_at_done", int'(e.who ? Gnt1 : Gnt0), 1);
          cur_clear = e.clear;
          stage     = 1;
        end
        en_cnt = 0;
        done_cnt++;
      end else begin
        chk("wrap_without_done", int'(Wrap), 0);
      end
    end
  end

  task automatic chk_all_zero(string tag);
    chk({tag, "_gnt0"}, int'(Gnt0), 0);
    chk({tag, "_gnt1"}, int'(Gnt1), 0);
    chk({tag, "_cnten"}, int'(CntEn), 0);
    chk({tag, "_cntreset"}, int'(CntReset), 0);
    chk({tag, "_done0"}, int'(Done0), 0);
    chk({tag, "_done1"}, int'(Done1), 0);
    chk({tag, "_wrap"}, int'(Wrap), 0);
    chk({tag, "_busy"}, int'(Busy), 0);
  endtask

  task automatic wait_done(int target);
    for (int i = 0; i < 300 && done_cnt < target; i++) @(negedge Clk);
    if (done_cnt < target) begin
      checks++;
      fails++;
      $display("FAIL done_timeout: got %0d completions expected %0d", done_cnt, target);
      abort = 1'b1;
    end
  endtask

  // One transaction: raise requests, predict every burst they yield, wait, drain.
  task automatic run_txn(bit r0, bit r1, logic [2:0] l0, logic [2:0] l1, int nb, bit drop);
    bit who;
    if (abort) return;
    for (int k = 0; k < nb; k++) begin
      who = pick(r0, r1);
      predict(who, who ? l1 : l0);
    end
    exp_done = exp_done + nb;
    Req0 = r0;
    Req1 = r1;
    Len0 = l0;
    Len1 = l1;
    if (drop) begin
      @(negedge Clk);
      Req0 = 1'b0;
      Req1 = 1'b0;
      Len0 = 3'($urandom);
      Len1 = 3'($urandom);
    end
    wait_done(exp_done);
    Req0 = 1'b0;
    Req1 = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic pre_wrap();
    force_ovf = 1'b1;
    @(negedge Clk);
    force_ovf = 1'b0;
    m_sticky  = 1'b1;
  endtask

  initial begin
    int mode;
    bit r0, r1;
    #12;
    chk_all_zero("reset");
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    run_txn(1'b1, 1'b0, 3'd3, 3'd0, 1, 1'b0);
    run_txn(1'b1, 1'b1, 3'd2, 3'd2, 4, 1'b0);
    run_txn(1'b1, 1'b0, 3'd5, 3'd0, 1, 1'b1);
    pre_wrap();
    run_txn(1'b1, 1'b0, 3'd1, 3'd0, 1, 1'b0);

    // Reset in the middle of a burst, then a lone Req1 with the counter freshly zeroed.
    Req0 = 1'b1;
    Len0 = 3'd6;
    repeat (3) @(negedge Clk);
    #2 Reset = 1'b1;
    #1 chk_all_zero("midreset");
    Req0 = 1'b0;
    @(negedge Clk);
    sbq.delete();
    m_pos    = 0;
    m_sticky = 1'b0;
    m_last   = 1'b1;
    #2 Reset = 1'b0;
    @(negedge Clk);
    run_txn(1'b0, 1'b1, 3'd0, 3'd0, 1, 1'b0);

    for (int t = 0; t < 40 && !abort; t++) begin
      mode = int'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) pre_wrap();
      case (mode)
        0: run_txn(1'b1, 1'b0, 3'($urandom), 3'($urandom), int'($urandom_range(1, 2)), 1'b0);
        1: run_txn(1'b0, 1'b1, 3'($urandom), 3'($urandom), int'($urandom_range(1, 2)), 1'b0);
        2: run_txn(1'b1, 1'b1, 3'($urandom), 3'($urandom), int'($urandom_range(1, 4)), 1'b0);
        default: begin
          r0 = 1'($urandom);
          r1 = r0 ? 1'($urandom) : 1'b1;
          run_txn(r0, r1, 3'($urandom), 3'($urandom), 1, 1'b1);
        end
      endcase
    end

    if (sbq.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL leftover_expected: got %0d pending expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
